// File: rtl/hero_write_rx.sv
// hero_write_rx: assembles VALID..DONE hero beat sequences into parallel write records
// delivered over valid/ready, flagging empty, overflowing and illegal sequences.
module hero_write_rx #(
    parameter int HERO_WIDTH = 8,
    parameter int MAX_BEATS  = 4,
    parameter int CNT_W      = 16,
    localparam int CW        = $clog2(MAX_BEATS + 1),
    localparam int IW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      hero_cycle,
    input  logic [HERO_WIDTH-1:0]           hero_data,
    output logic                            hero_rdy,
    output logic                            wr_vld,
    input  logic                            wr_rdy,
    output logic [MAX_BEATS*HERO_WIDTH-1:0] wr_data,
    output logic [CW-1:0]                   wr_beats,
    output logic                            err_empty,
    output logic                            err_ovf,
    output logic                            err_code,
    output logic [CNT_W-1:0]                done_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DROP, S_HOLD} state_t;

    localparam logic [1:0] C_VALID = 2'd1;
    localparam logic [1:0] C_DONE  = 2'd2;
    localparam logic [1:0] C_ILL   = 2'd3;

    state_t                                r_state;
    logic [MAX_BEATS-1:0][HERO_WIDTH-1:0]  r_lanes;
    logic [CW-1:0]                         r_cnt;
    logic                                  r_rdy;
    logic                                  r_vld;
    logic                                  r_err_empty;
    logic                                  r_err_ovf;
    logic                                  r_err_code;
    logic [CNT_W-1:0]                      r_done_cnt;
    logic                                  w_acc;

    assign w_acc     = r_rdy && (hero_cycle != 2'd0);
    assign hero_rdy  = r_rdy;
    assign wr_vld    = r_vld;
    assign wr_data   = r_lanes;
    assign wr_beats  = r_cnt;
    assign err_empty = r_err_empty;
    assign err_ovf   = r_err_ovf;
    assign err_code  = r_err_code;
    assign done_cnt  = r_done_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lanes     <= '0;
            r_cnt       <= '0;
            r_rdy       <= 1'b0;
            r_vld       <= 1'b0;
            r_err_empty <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_code  <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            r_rdy       <= 1'b1;
            r_err_empty <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_code  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc && hero_cycle == C_VALID) begin
                        r_lanes[0] <= hero_data;
                        r_cnt      <= CW'(1);
                        r_state    <= S_COLLECT;
                    end
                    r_err_empty <= w_acc && hero_cycle == C_DONE;
                    r_err_code  <= w_acc && hero_cycle == C_ILL;
                end
                S_COLLECT: begin
                    if (w_acc && hero_cycle == C_VALID) begin
                        if (r_cnt < CW'(MAX_BEATS)) begin
                            r_lanes[r_cnt[IW-1:0]] <= hero_data;
                            r_cnt                  <= r_cnt + CW'(1);
                        end else begin
                            r_err_ovf <= 1'b1;
                            r_state   <= S_DROP;
                        end
                    end else if (w_acc && hero_cycle == C_DONE) begin
                        r_rdy   <= 1'b0;
                        r_vld   <= 1'b1;
                        r_state <= S_HOLD;
                    end else if (w_acc && hero_cycle == C_ILL) begin
                        r_err_code <= 1'b1;
                        r_lanes    <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (w_acc && hero_cycle != C_VALID) begin
                        r_err_code <= hero_cycle == C_ILL;
                        r_lanes    <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    // hero_rdy stays low until the cycle after the handshake
                    r_rdy <= wr_rdy;
                    if (wr_rdy) begin
                        r_vld      <= 1'b0;
                        r_done_cnt <= r_done_cnt + CNT_W'(1);
                        r_lanes    <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hero_write_rx.sv
// tb_hero_write_rx: directed checks of hero_write_rx (CNT_W=2 so the counter wraps).
module tb_hero_write_rx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  hero_cycle;
    logic [7:0]  hero_data;
    logic        hero_rdy;
    logic        wr_vld;
    logic        wr_rdy;
    logic [31:0] wr_data;
    logic [2:0]  wr_beats;
    logic        err_empty;
    logic        err_ovf;
    logic        err_code;
    logic [1:0]  done_cnt;
    int          tests = 0;
    int          fails = 0;

    hero_write_rx #(.HERO_WIDTH(8), .MAX_BEATS(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .hero_cycle(hero_cycle), .hero_data(hero_data),
        .hero_rdy(hero_rdy), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
        .wr_beats(wr_beats), .err_empty(err_empty), .err_ovf(err_ovf),
        .err_code(err_code), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] c, input logic [7:0] d);
        hero_cycle = c;
        hero_data  = d;
        tick();
        hero_cycle = 2'd0;
        hero_data  = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0; wr_rdy = 1'b0; hero_cycle = 2'd0; hero_data = 8'h00;
        tick(); tick();
        chk("rst_hero_rdy", {31'd0, hero_rdy}, 32'd0);
        chk("rst_wr_vld", {31'd0, wr_vld}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_wr_beats", {29'd0, wr_beats}, 32'd0);
        chk("rst_errs", {29'd0, err_empty, err_ovf, err_code}, 32'd0);
        chk("rst_done_cnt", {30'd0, done_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", {31'd0, hero_rdy}, 32'd1);

        // basic write
        wr_rdy = 1'b1;
        beat(2'd1, 8'h11); beat(2'd1, 8'h22); beat(2'd1, 8'h33); beat(2'd2, 8'h00);
        chk("basic_vld", {31'd0, wr_vld}, 32'd1);
        chk("basic_rdy_low", {31'd0, hero_rdy}, 32'd0);
        chk("basic_data", wr_data, 32'h0033_2211);
        chk("basic_beats", {29'd0, wr_beats}, 32'd3);
        tick();
        chk("basic_vld_drop", {31'd0, wr_vld}, 32'd0);
        chk("basic_rdy_back", {31'd0, hero_rdy}, 32'd1);
        chk("basic_cnt", {30'd0, done_cnt}, 32'd1);

        // backpressure with gaps
        wr_rdy = 1'b0;
        beat(2'd1, 8'hAA); tick(); tick(); beat(2'd1, 8'hBB); beat(2'd2, 8'h00);
        hero_cycle = 2'd2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", {31'd0, wr_vld}, 32'd1);
            chk("bp_data", wr_data, 32'h0000_BBAA);
            chk("bp_rdy", {31'd0, hero_rdy}, 32'd0);
            tick();
            chk("bp_no_accept", {31'd0, err_empty}, 32'd0);
        end
        wr_rdy = 1'b1;
        tick();
        chk("bp_hs_vld", {31'd0, wr_vld}, 32'd0);
        chk("bp_hs_rdy", {31'd0, hero_rdy}, 32'd1);
        chk("bp_cnt", {30'd0, done_cnt}, 32'd2);
        tick();
        hero_cycle = 2'd0;
        chk("bp_done_late_accept", {31'd0, err_empty}, 32'd1);
        tick();
        chk("bp_err_clear", {31'd0, err_empty}, 32'd0);

        // overflow
        for (int i = 1; i <= 4; i++) beat(2'd1, 8'(i));
        chk("ovf_none_at_4", {31'd0, err_ovf}, 32'd0);
        beat(2'd1, 8'h05);
        chk("ovf_pulse", {31'd0, err_ovf}, 32'd1);
        beat(2'd1, 8'h06);
        chk("ovf_single", {31'd0, err_ovf}, 32'd0);
        beat(2'd2, 8'h00);
        chk("ovf_no_vld", {31'd0, wr_vld}, 32'd0);
        tick();
        chk("ovf_no_vld2", {31'd0, wr_vld}, 32'd0);
        chk("ovf_cnt", {30'd0, done_cnt}, 32'd2);
        beat(2'd1, 8'h7E); beat(2'd2, 8'h00);
        chk("ovf_next_vld", {31'd0, wr_vld}, 32'd1);
        chk("ovf_next_data", wr_data, 32'h0000_007E);
        chk("ovf_next_beats", {29'd0, wr_beats}, 32'd1);
        tick();
        chk("ovf_next_cnt", {30'd0, done_cnt}, 32'd3);

        // empty / illegal
        beat(2'd2, 8'h00);
        chk("empty_pulse", {31'd0, err_empty}, 32'd1);
        chk("empty_no_vld", {31'd0, wr_vld}, 32'd0);
        beat(2'd1, 8'h44); beat(2'd3, 8'h00);
        chk("code_pulse", {31'd0, err_code}, 32'd1);
        chk("code_no_vld", {31'd0, wr_vld}, 32'd0);
        beat(2'd1, 8'h55);
        chk("code_clear", {31'd0, err_code}, 32'd0);
        beat(2'd2, 8'h00);
        chk("code_next_data", wr_data, 32'h0000_0055);
        chk("code_next_beats", {29'd0, wr_beats}, 32'd1);
        tick();
        chk("cnt_wrap_first", {30'd0, done_cnt}, 32'd0);

        // exactly MAX_BEATS
        beat(2'd1, 8'hDE); beat(2'd1, 8'hAD); beat(2'd1, 8'hBE); beat(2'd1, 8'hEF);
        chk("max_no_ovf", {31'd0, err_ovf}, 32'd0);
        beat(2'd2, 8'h00);
        chk("max_data", wr_data, 32'hEFBE_ADDE);
        chk("max_beats", {29'd0, wr_beats}, 32'd4);
        tick();
        chk("max_cnt", {30'd0, done_cnt}, 32'd1);

        // reset during hold
        wr_rdy = 1'b0;
        beat(2'd1, 8'h12); beat(2'd2, 8'h00);
        chk("hold_vld", {31'd0, wr_vld}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_vld", {31'd0, wr_vld}, 32'd0);
        chk("mid_rst_rdy", {31'd0, hero_rdy}, 32'd0);
        chk("mid_rst_data", wr_data, 32'd0);
        chk("mid_rst_beats", {29'd0, wr_beats}, 32'd0);
        chk("mid_rst_cnt", {30'd0, done_cnt}, 32'd0);
        rst_n = 1'b1; wr_rdy = 1'b1;
        tick();
        chk("post_rst_rdy", {31'd0, hero_rdy}, 32'd1);
        chk("post_rst_vld", {31'd0, wr_vld}, 32'd0);

        // counter wrap 1,2,3,0
        for (int i = 0; i < 4; i++) begin
            beat(2'd1, 8'(8'hA0 + i)); beat(2'd2, 8'h00);
            chk("wrap_data", wr_data, 32'(8'hA0 + i));
            tick();
            chk("wrap_cnt", {30'd0, done_cnt}, 32'((i + 1) % 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
